// File: rtl/controlador_dupla_rampa_pkg.sv
// rtl/controlador_dupla_rampa_pkg.sv - state encoding and full-scale constant for the dual-slope ADC controller
`timescale 1ns/1ps
package controlador_dupla_rampa_pkg;

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    AUTOZERO   = 3'd1,
    INTEGRA    = 3'd2,
    DESINTEGRA = 3'd3,
    CARREGA    = 3'd4
  } estado_t;

  localparam int N_INTEGRA = 1000;

endpackage

// File: rtl/controlador_dupla_rampa_temporizador_zero.sv
// rtl/controlador_dupla_rampa_temporizador_zero.sv - loadable auto-zero down-counter, saturating at zero
`timescale 1ns/1ps
module temporizador_zero #(
  parameter int T_ZERO = 8
) (
  input  logic ck,
  input  logic rst,
  input  logic carga,
  output logic fim,
  output logic primeiro
);

  localparam int W = $clog2(T_ZERO + 1);
  localparam logic [W-1:0] INICIAL = W'(T_ZERO - 1);

  logic [W-1:0] cont_q, cont_d;

  // Loaded with T_ZERO-1 so that fim marks the last of exactly T_ZERO cycles.
  always_comb begin
    cont_d = cont_q;
    if (carga) begin
      cont_d = INICIAL;
    end else if (cont_q != '0) begin
      cont_d = cont_q - 1'b1;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign fim      = (cont_q == '0);
  assign primeiro = (cont_q == INICIAL);

endmodule

// File: rtl/controlador_dupla_rampa.sv
// rtl/controlador_dupla_rampa.sv - dual-slope ADC control FSM driving the BCD counter and integrator switches
// Optional CONVERSAO_CONTINUA_EN: restart auto-zero after every conversion without waiting for inicio.
`timescale 1ns/1ps
module controlador_dupla_rampa
  import controlador_dupla_rampa_pkg::*;
#(
  parameter int T_ZERO = 8
) (
  input  logic ck,
  input  logic rst,
  input  logic inicio,
  input  logic Vint_z,
  input  logic enb_3,
  output logic rst_s,
  output logic enb_0,
  output logic ld,
  output logic ch_zr,
  output logic ch_vm,
  output logic ch_ref,
  output logic ocupado,
  output logic estouro
);

  estado_t estado_q, estado_d;
  logic    estouro_q, estouro_d;
  logic    carga_tmr, tmr_fim, tmr_primeiro;
  logic    base_enb;

  temporizador_zero #(.T_ZERO(T_ZERO)) u_temporizador (
    .ck       (ck),
    .rst      (rst),
    .carga    (carga_tmr),
    .fim      (tmr_fim),
    .primeiro (tmr_primeiro)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      estouro_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      estouro_q <= estouro_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    estouro_d = estouro_q;
    carga_tmr = 1'b0;
    rst_s     = 1'b0;
    base_enb  = 1'b0;
    ld        = 1'b0;
    ch_zr     = 1'b0;
    ch_vm     = 1'b0;
    ch_ref    = 1'b0;
    ocupado   = 1'b1;
    case (estado_q)
      OCIOSO: begin
        ch_zr   = 1'b1;
        ocupado = 1'b0;
        if (inicio) begin
          estado_d  = AUTOZERO;
          estouro_d = 1'b0;
          carga_tmr = 1'b1;
        end
      end
      AUTOZERO: begin
        ch_zr = 1'b1;
        rst_s = tmr_primeiro;
        if (tmr_fim) estado_d = INTEGRA;
      end
      INTEGRA: begin
        ch_vm    = 1'b1;
        base_enb = 1'b1;
        if (enb_3) estado_d = DESINTEGRA;
      end
      DESINTEGRA: begin
        ch_ref   = 1'b1;
        base_enb = 1'b1;
        if (Vint_z) begin
          estado_d = CARREGA;
        end else if (enb_3) begin
          // Overflow flag is set even when continuous mode restarts at once,
          // so the over-range result stays visible through the next auto-zero.
          estouro_d = 1'b1;
`ifdef CONVERSAO_CONTINUA_EN
          estado_d  = AUTOZERO;
          carga_tmr = 1'b1;
`else
          estado_d  = OCIOSO;
`endif
        end
      end
      CARREGA: begin
        ld    = 1'b1;
        ch_zr = 1'b1;
`ifdef CONVERSAO_CONTINUA_EN
        estado_d  = AUTOZERO;
        estouro_d = 1'b0;
        carga_tmr = 1'b1;
`else
        estado_d  = OCIOSO;
`endif
      end
      default: begin
        estado_d = OCIOSO;
        ch_zr    = 1'b1;
        ocupado  = 1'b0;
      end
    endcase
  end

  // Zero crossing freezes the count in the very cycle it is seen.
  assign enb_0   = base_enb & ~((estado_q == DESINTEGRA) & Vint_z);
  assign estouro = estouro_q;

endmodule

// File: tb/tb_controlador_dupla_rampa.sv
// tb/tb_controlador_dupla_rampa.sv - scoreboard bench with a BCD counter model for the dual-slope controller
`timescale 1ns/1ps
module tb_controlador_dupla_rampa;
  import controlador_dupla_rampa_pkg::*;

`ifdef CONVERSAO_CONTINUA_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic ck = 1'b0;
  logic rst, inicio, Vint_z, enb_3;
  logic rst_s, enb_0, ld, ch_zr, ch_vm, ch_ref, ocupado, estouro;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         eh_carga;
    logic [11:0] valor;
  } esp_t;
  esp_t fila[$];

  always #5 ck = ~ck;

  controlador_dupla_rampa #(.T_ZERO(8)) dut (
    .ck      (ck),
    .rst     (rst),
    .inicio  (inicio),
    .Vint_z  (Vint_z),
    .enb_3   (enb_3),
    .rst_s   (rst_s),
    .enb_0   (enb_0),
    .ld      (ld),
    .ch_zr   (ch_zr),
    .ch_vm   (ch_vm),
    .ch_ref  (ch_ref),
    .ocupado (ocupado),
    .estouro (estouro)
  );

  // Behavioural model of bcd_controlador_3digitos.
  logic [3:0] d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  assign enb_3 = enb_0 && d2 == 4'd9 && d1 == 4'd9 && d0 == 4'd9;

  always @(posedge ck) begin
    if (rst_s) begin
      d2 <= 4'd0; d1 <= 4'd0; d0 <= 4'd0;
    end else if (enb_0) begin
      if (d0 != 4'd9) d0 <= d0 + 4'd1;
      else begin
        d0 <= 4'd0;
        if (d1 != 4'd9) d1 <= d1 + 4'd1;
        else begin
          d1 <= 4'd0;
          d2 <= (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
        end
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  task automatic chk_reset(input string nome);
    chk(nome, {rst_s, enb_0, ld, ch_zr, ch_vm, ch_ref, ocupado, estouro}, 8'b0001_0000);
  endtask

  // Monitor: ld pulses and ocupado falling edges are the observable conversion events.
  logic ocupado_ant = 1'b0;
  always @(negedge ck) begin
    esp_t e;
    if (ld) begin
      if (fila.size() == 0) chk("ld_inesperado", 1, 0);
      else begin
        e = fila.pop_front();
        chk("evento_ld_tipo", 1, e.eh_carga);
        if (e.eh_carga) chk("display", {d2, d1, d0}, e.valor);
      end
    end
    if (ocupado_ant && !ocupado) begin
      if (fila.size() == 0) chk("fim_inesperado", 1, 0);
      else begin
        e = fila.pop_front();
        chk("evento_fim_tipo", 0, e.eh_carga);
        if (!e.eh_carga) chk("estouro_no_fim", estouro, e.valor[0]);
      end
    end
    ocupado_ant <= ocupado;
  end

  // d < 0 means Vint_z never rises during de-integration.
  task automatic conv(input bit pulso, input int d, input logic [11:0] bcd);
    int n, r, bad;
    logic primeiro_rst;
    if (pulso) begin
      inicio = 1'b1;
      @(negedge ck);
      inicio = 1'b0;
    end else begin
      @(negedge ck);
    end
    chk("estouro_limpo", estouro, 0);
    n = 0; r = 0; primeiro_rst = rst_s;
    while (ch_zr && ocupado && n < 100) begin
      if (rst_s) r++;
      n++;
      @(negedge ck);
    end
    chk("autozero_len", n, 8);
    chk("rst_s_primeiro", primeiro_rst, 1);
    chk("rst_s_pulsos", r, 1);
    n = 0; bad = 0;
    while (ch_vm && n < 1100) begin
      if (!enb_0) bad++;
      n++;
      @(negedge ck);
    end
    chk("integra_len", n, N_INTEGRA);
    chk("integra_enb0_baixo", bad, 0);
    chk("ch_ref_apos_integra", {ch_zr, ch_vm, ch_ref}, 3'b001);
    if (d >= 0) begin
      fila.push_back('{1'b1, bcd});
      if (!CONT) fila.push_back('{1'b0, 12'h000});
    end else begin
      fila.push_back('{1'b0, 12'h001});
    end
    n = 0;
    while (ch_ref && n < 1100) begin
      if (n == d) begin
        Vint_z = 1'b1;
        #1;
        chk("enb_0_cortado", enb_0, 0);
      end
      n++;
      @(negedge ck);
      Vint_z = 1'b0;
    end
    if (d >= 0) begin
      chk("desintegra_len", n, d + 1);
      chk("ld_carrega", {ld, ch_zr}, 2'b11);
      @(negedge ck);
      chk("ocupado_apos", ocupado, CONT);
    end else begin
      chk("desintegra_estouro_len", n, N_INTEGRA);
      chk("ocupado_apos_estouro", ocupado, 0);
      chk("estouro_setado", estouro, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; inicio = 1'b0; Vint_z = 1'b0;
    repeat (3) @(negedge ck);
    chk_reset("reset_ocioso");
    rst = 1'b0;
    @(negedge ck);
    chk_reset("ocioso_apos_reset");

    inicio = 1'b1;
    @(negedge ck);
    inicio = 1'b0;
    repeat (20) @(negedge ck);
    chk("em_integra", ch_vm, 1);
    fila.push_back('{1'b0, 12'h000});
    #2 rst = 1'b1;
    #1 chk_reset("reset_meio_integra");
    @(negedge ck);
    rst = 1'b0;
    @(negedge ck);

`ifdef CONVERSAO_CONTINUA_EN
    conv(1'b1, 100, 12'h100);
    conv(1'b0, 300, 12'h300);
`else
    conv(1'b1, 250, 12'h250);
    conv(1'b1, 0, 12'h000);
    conv(1'b1, -1, 12'h000);
    conv(1'b1, 250, 12'h250);
`endif

    repeat (3) @(negedge ck);
    chk("fila_vazia", fila.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
